// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating stall counter.
// Optional feature macro: LOAD_USE_STALL_EN enables the hazard/stall logic; without it stall_o and stall_cnt_o are tied 0.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid_i,
  input  logic        alu_src_i,
  input  logic        mem_to_reg_i,
  input  logic        reg_write_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        branch_i,
  input  logic [1:0]  alu_op_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rd1_i,
  input  logic [31:0] rd2_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [4:0]  rd_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic        flush_i,
  output logic        ex_alu_src_o,
  output logic        ex_mem_to_reg_o,
  output logic        ex_reg_write_o,
  output logic        ex_mem_read_o,
  output logic        ex_mem_write_o,
  output logic        ex_branch_o,
  output logic [1:0]  ex_alu_op_o,
  output logic [31:0] ex_pc_o,
  output logic [31:0] ex_rd1_o,
  output logic [31:0] ex_rd2_o,
  output logic [31:0] ex_imm_o,
  output logic [4:0]  ex_rs1_o,
  output logic [4:0]  ex_rs2_o,
  output logic [4:0]  ex_rd_o,
  output logic [2:0]  ex_funct3_o,
  output logic [6:0]  ex_funct7_o,
  output logic        ex_valid_o,
  output logic        stall_o,
  output logic [15:0] stall_cnt_o
);

  typedef struct packed {
    logic        alu_src;
    logic        mem_to_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic [1:0]  alu_op;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
  } ex_t;

  ex_t  ex_q, ex_d;
  logic ex_valid_q, ex_valid_d;
  logic stall;

`ifdef LOAD_USE_STALL_EN
  logic        hazard;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // A load in EX whose destination is read by the ID instruction needs one bubble.
  assign hazard = ex_valid_q & ex_q.mem_read & (ex_q.rd != 5'd0) & id_valid_i &
                  ((rs1_i == ex_q.rd) | (rs2_i == ex_q.rd));
  assign stall  = hazard & ~flush_i & ~reset;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= 16'd0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall       = 1'b0;
  assign stall_cnt_o = 16'd0;
`endif

  assign stall_o = stall;

  // Flush and stall both load a bubble; an invalid ID slot still carries its fields but no control.
  always_comb begin
    ex_d       = '0;
    ex_valid_d = 1'b0;
    if (!flush_i && !stall) begin
      ex_valid_d = id_valid_i;
      ex_d.pc     = pc_i;
      ex_d.rd1    = rd1_i;
      ex_d.rd2    = rd2_i;
      ex_d.imm    = imm_i;
      ex_d.rs1    = rs1_i;
      ex_d.rs2    = rs2_i;
      ex_d.rd     = rd_i;
      ex_d.funct3 = funct3_i;
      ex_d.funct7 = funct7_i;
      if (id_valid_i) begin
        ex_d.alu_src    = alu_src_i;
        ex_d.mem_to_reg = mem_to_reg_i;
        ex_d.reg_write  = reg_write_i;
        ex_d.mem_read   = mem_read_i;
        ex_d.mem_write  = mem_write_i;
        ex_d.branch     = branch_i;
        ex_d.alu_op     = alu_op_i;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign ex_alu_src_o    = ex_q.alu_src;
  assign ex_mem_to_reg_o = ex_q.mem_to_reg;
  assign ex_reg_write_o  = ex_q.reg_write;
  assign ex_mem_read_o   = ex_q.mem_read;
  assign ex_mem_write_o  = ex_q.mem_write;
  assign ex_branch_o     = ex_q.branch;
  assign ex_alu_op_o     = ex_q.alu_op;
  assign ex_pc_o         = ex_q.pc;
  assign ex_rd1_o        = ex_q.rd1;
  assign ex_rd2_o        = ex_q.rd2;
  assign ex_imm_o        = ex_q.imm;
  assign ex_rs1_o        = ex_q.rs1;
  assign ex_rs2_o        = ex_q.rs2;
  assign ex_rd_o         = ex_q.rd;
  assign ex_funct3_o     = ex_q.funct3;
  assign ex_funct7_o     = ex_q.funct7;
  assign ex_valid_o      = ex_valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table, directed hazard sequences, random run vs. a pipeline model.
// Honours LOAD_USE_STALL_EN the same way as the design.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic        alu_src;
    logic        mem_to_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic [1:0]  alu_op;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
  } bundle_t;

  typedef struct {
    bundle_t     in;
    logic        fl;
    logic        exp_valid;
    logic        exp_rw;
    logic [31:0] exp_pc;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  bundle_t in_s;
  logic flush;
  bundle_t act;
  logic ex_valid_o, stall_o;
  logic ex_alu_src_o, ex_mem_to_reg_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_branch_o;
  logic [1:0]  ex_alu_op_o;
  logic [31:0] ex_pc_o, ex_rd1_o, ex_rd2_o, ex_imm_o;
  logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [2:0]  ex_funct3_o;
  logic [6:0]  ex_funct7_o;
  logic [15:0] stall_cnt_o;

  int n_pass = 0;
  int n_total = 0;
  bundle_t model;
  int model_cnt;
  logic last_stall;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid_i(in_s.valid),
    .alu_src_i(in_s.alu_src), .mem_to_reg_i(in_s.mem_to_reg), .reg_write_i(in_s.reg_write),
    .mem_read_i(in_s.mem_read), .mem_write_i(in_s.mem_write), .branch_i(in_s.branch),
    .alu_op_i(in_s.alu_op), .pc_i(in_s.pc), .rd1_i(in_s.rd1), .rd2_i(in_s.rd2), .imm_i(in_s.imm),
    .rs1_i(in_s.rs1), .rs2_i(in_s.rs2), .rd_i(in_s.rd), .funct3_i(in_s.funct3), .funct7_i(in_s.funct7),
    .flush_i(flush),
    .ex_alu_src_o(ex_alu_src_o), .ex_mem_to_reg_o(ex_mem_to_reg_o), .ex_reg_write_o(ex_reg_write_o),
    .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o), .ex_branch_o(ex_branch_o),
    .ex_alu_op_o(ex_alu_op_o), .ex_pc_o(ex_pc_o), .ex_rd1_o(ex_rd1_o), .ex_rd2_o(ex_rd2_o),
    .ex_imm_o(ex_imm_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
    .ex_funct3_o(ex_funct3_o), .ex_funct7_o(ex_funct7_o), .ex_valid_o(ex_valid_o),
    .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
  );

  always_comb begin
    act            = '0;
    act.valid      = ex_valid_o;
    act.alu_src    = ex_alu_src_o;
    act.mem_to_reg = ex_mem_to_reg_o;
    act.reg_write  = ex_reg_write_o;
    act.mem_read   = ex_mem_read_o;
    act.mem_write  = ex_mem_write_o;
    act.branch     = ex_branch_o;
    act.alu_op     = ex_alu_op_o;
    act.pc         = ex_pc_o;
    act.rd1        = ex_rd1_o;
    act.rd2        = ex_rd2_o;
    act.imm        = ex_imm_o;
    act.rs1        = ex_rs1_o;
    act.rs2        = ex_rs2_o;
    act.rd         = ex_rd_o;
    act.funct3     = ex_funct3_o;
    act.funct7     = ex_funct7_o;
  end

  task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // A load sitting in EX blocks any real ID instruction that reads its (nonzero) destination.
  function automatic logic model_stall(input bundle_t ex, input bundle_t id, input logic fl);
`ifdef LOAD_USE_STALL_EN
    if (fl || !ex.valid || !ex.mem_read || ex.rd == 5'd0 || !id.valid) return 1'b0;
    return (id.rs1 == ex.rd) || (id.rs2 == ex.rd);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bundle_t model_next(input bundle_t id, input logic fl, input logic st);
    bundle_t r;
    if (fl || st) return '0;
    r = id;
    if (!id.valid) begin
      r.alu_src = 0; r.mem_to_reg = 0; r.reg_write = 0; r.mem_read = 0;
      r.mem_write = 0; r.branch = 0; r.alu_op = 2'b00;
    end
    return r;
  endfunction

  function automatic bundle_t mk(input logic v, input logic mr, input logic rw,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic [31:0] pc);
    bundle_t b;
    b = '0;
    b.valid = v; b.mem_read = mr; b.reg_write = rw; b.mem_to_reg = mr; b.alu_src = mr;
    b.alu_op = mr ? 2'b00 : 2'b10;
    b.rs1 = rs1; b.rs2 = rs2; b.rd = rd; b.pc = pc;
    b.rd1 = pc ^ 32'hA5A5_0001; b.rd2 = pc + 32'd77; b.imm = ~pc;
    b.funct3 = pc[4:2]; b.funct7 = pc[10:4];
    return b;
  endfunction

  task automatic step(input bundle_t id, input logic fl);
    @(negedge clk);
    in_s  = id;
    flush = fl;
    #1;
    last_stall = model_stall(model, id, fl);
    check("stall_o", stall_o, last_stall);
    @(posedge clk);
    #1;
    if (last_stall && model_cnt < 65535) model_cnt++;
    model = model_next(id, fl, last_stall);
    check("ex_outputs", act, model);
    check("stall_cnt", stall_cnt_o, model_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_outputs", act, '0);
    check("rst_stall_cnt", stall_cnt_o, 0);
    check("rst_stall_o", stall_o, 0);
    @(negedge clk);
    reset = 1'b0;
    model = '0;
    model_cnt = 0;
  endtask

  vec_t tbl[6];
  bundle_t r;
  int base;

  initial begin
    // Reset at time 0 with busy inputs.
    reset = 1'b1;
    in_s  = mk(1, 1, 1, 5'd3, 5'd4, 5'd9, 32'h1234_5678);
    flush = 1'b0;
    model = '0;
    model_cnt = 0;
    last_stall = 1'b0;
    #3;
    check("t0_outputs", act, '0);
    check("t0_stall_cnt", stall_cnt_o, 0);
    check("t0_stall_o", stall_o, 0);
    @(negedge clk);
    reset = 1'b0;

    // Vector table: no loads, so only capture/flush/invalid behaviour is exercised.
    tbl[0] = '{mk(1, 0, 1, 5'd1, 5'd2, 5'd3, 32'h0000_0100), 1'b0, 1'b1, 1'b1, 32'h0000_0100};
    tbl[1] = '{mk(1, 0, 0, 5'd4, 5'd5, 5'd6, 32'h0000_0104), 1'b0, 1'b1, 1'b0, 32'h0000_0104};
    tbl[2] = '{mk(0, 0, 1, 5'd7, 5'd8, 5'd9, 32'h0000_0108), 1'b0, 1'b0, 1'b0, 32'h0000_0108};
    tbl[3] = '{mk(1, 0, 1, 5'd1, 5'd1, 5'd1, 32'h0000_010C), 1'b1, 1'b0, 1'b0, 32'h0000_0000};
    tbl[4] = '{mk(0, 0, 0, 5'd2, 5'd2, 5'd2, 32'h0000_0110), 1'b1, 1'b0, 1'b0, 32'h0000_0000};
    tbl[5] = '{mk(1, 0, 1, 5'd31, 5'd30, 5'd29, 32'hFFFF_FFFC), 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC};
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].in, tbl[i].fl);
      check("tbl_valid", ex_valid_o, tbl[i].exp_valid);
      check("tbl_reg_write", ex_reg_write_o, tbl[i].exp_rw);
      check("tbl_pc", ex_pc_o, tbl[i].exp_pc);
    end

    // LW x5 then ADD x7, x5, x6.
    base = model_cnt;
    step(mk(1, 1, 1, 5'd1, 5'd2, 5'd5, 32'h200), 1'b0);
    step(mk(1, 0, 1, 5'd5, 5'd6, 5'd7, 32'h204), 1'b0);
`ifdef LOAD_USE_STALL_EN
    check("lu_stall", last_stall, 1);
    check("lu_bubble_valid", ex_valid_o, 0);
    check("lu_bubble_rw", ex_reg_write_o, 0);
    step(mk(1, 0, 1, 5'd5, 5'd6, 5'd7, 32'h204), 1'b0);
    check("lu_second_stall", last_stall, 0);
    check("lu_add_valid", ex_valid_o, 1);
    check("lu_add_rs1", ex_rs1_o, 5);
    check("lu_cnt", stall_cnt_o, base + 1);
`else
    check("nostall_valid", ex_valid_o, 1);
    check("nostall_rs1", ex_rs1_o, 5);
    check("nostall_pc", ex_pc_o, 32'h204);
    check("nostall_cnt", stall_cnt_o, 0);
`endif

    // LW x0 then a reader of x0: never stalls.
    step(mk(1, 1, 1, 5'd1, 5'd2, 5'd0, 32'h300), 1'b0);
    step(mk(1, 0, 1, 5'd0, 5'd0, 5'd8, 32'h304), 1'b0);
    check("x0_valid", ex_valid_o, 1);
    check("x0_pc", ex_pc_o, 32'h304);

    // Hazard coinciding with flush: flush wins, counter untouched.
    base = stall_cnt_o;
    step(mk(1, 1, 1, 5'd1, 5'd2, 5'd9, 32'h400), 1'b0);
    step(mk(1, 0, 1, 5'd3, 5'd9, 5'd10, 32'h404), 1'b1);
    check("fl_stall", stall_o, 0);
    check("fl_valid", ex_valid_o, 0);
    check("fl_pc", ex_pc_o, 0);
    check("fl_cnt", stall_cnt_o, base);

    // Reset in the middle of a stall cycle.
    step(mk(1, 1, 1, 5'd1, 5'd2, 5'd11, 32'h500), 1'b0);
    @(negedge clk);
    in_s = mk(1, 0, 1, 5'd11, 5'd2, 5'd12, 32'h504);
    #1;
    check("mid_stall", stall_o, model_stall(model, in_s, 1'b0));
    reset = 1'b1;
    #1;
    check("mid_rst_stall_o", stall_o, 0);
    check("mid_rst_outputs", act, '0);
    check("mid_rst_cnt", stall_cnt_o, 0);
    @(negedge clk);
    reset = 1'b0;
    model = '0;
    model_cnt = 0;
    step(mk(1, 0, 1, 5'd11, 5'd2, 5'd12, 32'h504), 1'b0);
    check("post_rst_valid", ex_valid_o, 1);

`ifdef LOAD_USE_STALL_EN
    // Counter saturation from a preloaded near-max value.
    @(negedge clk);
    force dut.stall_cnt_q = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;
    model_cnt = 65534;
    for (int k = 0; k < 3; k++) begin
      step(mk(1, 1, 1, 5'd1, 5'd2, 5'd13, 32'h600), 1'b0);
      step(mk(1, 0, 1, 5'd13, 5'd2, 5'd14, 32'h604), 1'b0);
      step(mk(1, 0, 1, 5'd13, 5'd2, 5'd14, 32'h604), 1'b0);
    end
    check("sat_cnt", stall_cnt_o, 16'hFFFF);
    do_reset();
`endif

    // Random traffic with small register numbers to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      r = mk($urandom_range(0, 9) < 8, $urandom_range(0, 1), $urandom_range(0, 1),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             $urandom);
      r.alu_src   = $urandom_range(0, 1);
      r.mem_write = $urandom_range(0, 1);
      r.branch    = $urandom_range(0, 1);
      r.alu_op    = 2'($urandom_range(0, 3));
      r.rd1       = $urandom;
      r.funct7    = 7'($urandom_range(0, 127));
      step(r, $urandom_range(0, 9) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
